// File: rtl/shift_load_pkg.sv
// Shared encodings for the shift/load register: single-cycle ops, burst FSM
// states, burst directions and the per-bit next-state mux selects.
package shift_load_pkg;

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_SHR  = 2'b10;
    localparam logic [1:0] OP_SHL  = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    // Bit-cell mux selects; "left" is the more significant neighbour.
    localparam logic [1:0] CELL_HOLD       = 2'b00;
    localparam logic [1:0] CELL_LOAD       = 2'b01;
    localparam logic [1:0] CELL_FROM_LEFT  = 2'b10;
    localparam logic [1:0] CELL_FROM_RIGHT = 2'b11;

endpackage

// File: rtl/shift_cell.sv
// One register bit: 4:1 next-state mux (hold/load/from-left/from-right)
// feeding a flop with asynchronous active-low reset.
module shift_cell
    import shift_load_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sel,
    input  logic       ld_d,
    input  logic       from_left,
    input  logic       from_right,
    output logic       q
);

    logic q_next;

    // Next-state select; hold keeps the bit when the register is idle or disabled.
    always_comb begin
        q_next = q;
        case (sel)
            CELL_HOLD:       q_next = q;
            CELL_LOAD:       q_next = ld_d;
            CELL_FROM_LEFT:  q_next = from_left;
            CELL_FROM_RIGHT: q_next = from_right;
            default:         q_next = q;
        endcase
    end

    // Storage flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= 1'b0;
        end else begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/shift_load_register.sv
// WIDTH-bit hold/load/shift register with synchronous clear and an autonomous
// multi-cycle shift burst (start/busy/done). Control decode and burst FSM live
// here; the datapath is WIDTH shift_cell instances.
module shift_load_register
    import shift_load_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ebl,
    input  logic             clr,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] L,
    input  logic             sin,
    input  logic             start,
    input  logic [CNT_W-1:0] amt,
    input  logic             dir,
    output logic [WIDTH-1:0] Q,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             dir_q;

    logic             shift_en;
    logic             shift_left;
    logic             ld_zero;
    logic [1:0]       cell_sel;
    logic [WIDTH-1:0] ld_data;
    logic [WIDTH-1:0] from_left_v;
    logic [WIDTH-1:0] from_right_v;

    assign busy = (state == ST_SHIFT);

    // Decode one action per enabled edge: clr > burst shift > start > op.
    always_comb begin
        shift_en   = 1'b0;
        shift_left = 1'b0;
        ld_zero    = 1'b0;
        cell_sel   = CELL_HOLD;
        if (ebl) begin
            if (clr) begin
                cell_sel = CELL_LOAD;
                ld_zero  = 1'b1;
            end else if (state == ST_SHIFT) begin
                shift_en   = 1'b1;
                shift_left = (dir_q == DIR_LEFT);
            end else if (!start) begin
                case (op)
                    OP_LOAD: cell_sel = CELL_LOAD;
                    OP_SHR:  shift_en = 1'b1;
                    OP_SHL: begin
                        shift_en   = 1'b1;
                        shift_left = 1'b1;
                    end
                    default: cell_sel = CELL_HOLD;
                endcase
            end
            if (shift_en) begin
                cell_sel = shift_left ? CELL_FROM_RIGHT : CELL_FROM_LEFT;
            end
        end
    end

    assign ld_data      = ld_zero ? '0 : L;
    assign from_left_v  = {sin, Q[WIDTH-1:1]};
    assign from_right_v = {Q[WIDTH-2:0], sin};

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        shift_cell u_cell (
            .clk        (clk),
            .rst        (rst),
            .sel        (cell_sel),
            .ld_d       (ld_data[i]),
            .from_left  (from_left_v[i]),
            .from_right (from_right_v[i]),
            .q          (Q[i])
        );
    end

    // Burst FSM, count, latched direction, sout capture and done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            count <= '0;
            dir_q <= DIR_RIGHT;
            sout  <= 1'b0;
            done  <= 1'b0;
        end else if (ebl) begin
            done <= 1'b0;
            if (shift_en) begin
                sout <= shift_left ? Q[WIDTH-1] : Q[0];
            end
            if (clr) begin
                state <= ST_IDLE;
                count <= '0;
            end else if (state == ST_SHIFT) begin
                count <= count - CNT_W'(1);
                if (count == CNT_W'(1)) begin
                    state <= ST_IDLE;
                    done  <= 1'b1;
                end
            end else if (start) begin
                if (amt != '0) begin
                    state <= ST_SHIFT;
                    count <= amt;
                    dir_q <= dir;
                end else begin
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_shift_load_register.sv
// Bench for shift_load_register: single-op vector table plus hand-written
// burst, stall, abort, back-to-back, long-burst and async-reset sequences.
module tb_shift_load_register;

    localparam int W  = 16;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          ebl, clr, sin, start, dir;
    logic [1:0]    op;
    logic [W-1:0]  L;
    logic [CW-1:0] amt;
    logic [W-1:0]  Q;
    logic          sout, busy, done;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [W-1:0] q;
        logic         sout;
        logic         busy;
        logic         done;
        string        tag;
    } exp_t;

    typedef struct {
        logic         ebl;
        logic         clr;
        logic [1:0]   op;
        logic [W-1:0] l;
        logic         sin;
        logic [W-1:0] q;
        logic         sout;
    } vec_t;

    exp_t sb[$];
    vec_t vt[11];

    shift_load_register #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst   (rst),
        .ebl   (ebl),
        .clr   (clr),
        .op    (op),
        .L     (L),
        .sin   (sin),
        .start (start),
        .amt   (amt),
        .dir   (dir),
        .Q     (Q),
        .sout  (sout),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic cmp(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, expv);
        end
    endtask

    task automatic drv(input logic e, input logic c, input logic [1:0] o, input logic [W-1:0] lv,
                       input logic s, input logic st, input logic [CW-1:0] a, input logic d);
        ebl = e; clr = c; op = o; L = lv; sin = s; start = st; amt = a; dir = d;
    endtask

    // Push the expectation for the coming edge, run the edge, pop and compare.
    task automatic exp_edge(input logic [W-1:0] q, input logic so, input logic b, input logic d,
                            input string tag);
        exp_t e;
        e = '{q, so, b, d, tag};
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        cmp({e.tag, ".Q"},    Q,                  e.q);
        cmp({e.tag, ".sout"}, {{(W-1){1'b0}}, sout}, {{(W-1){1'b0}}, e.sout});
        cmp({e.tag, ".busy"}, {{(W-1){1'b0}}, busy}, {{(W-1){1'b0}}, e.busy});
        cmp({e.tag, ".done"}, {{(W-1){1'b0}}, done}, {{(W-1){1'b0}}, e.done});
    endtask

    initial begin
        vt[0]  = '{1'b1, 1'b0, 2'b01, 16'h8001, 1'b0, 16'h8001, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 2'b11, 16'h0000, 1'b0, 16'h0002, 1'b1};
        vt[2]  = '{1'b1, 1'b0, 2'b10, 16'h0000, 1'b1, 16'h8001, 1'b0};
        vt[3]  = '{1'b1, 1'b0, 2'b00, 16'hFFFF, 1'b1, 16'h8001, 1'b0};
        vt[4]  = '{1'b0, 1'b0, 2'b01, 16'hFFFF, 1'b1, 16'h8001, 1'b0};
        vt[5]  = '{1'b1, 1'b1, 2'b01, 16'h1234, 1'b0, 16'h0000, 1'b0};
        vt[6]  = '{1'b1, 1'b0, 2'b01, 16'hC003, 1'b0, 16'hC003, 1'b0};
        vt[7]  = '{1'b1, 1'b0, 2'b10, 16'h0000, 1'b0, 16'h6001, 1'b1};
        vt[8]  = '{1'b1, 1'b0, 2'b11, 16'h0000, 1'b1, 16'hC003, 1'b0};
        vt[9]  = '{1'b1, 1'b1, 2'b11, 16'h0000, 1'b1, 16'h0000, 1'b0};
        vt[10] = '{1'b1, 1'b0, 2'b01, 16'hA5F0, 1'b0, 16'hA5F0, 1'b0};

        rst = 1'b0;
        drv(1'b1, 1'b0, 2'b00, 16'h0, 1'b0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        cmp("reset.Q", Q, 16'h0);
        cmp("reset.sout", {15'h0, sout}, 16'h0);
        cmp("reset.busy", {15'h0, busy}, 16'h0);
        cmp("reset.done", {15'h0, done}, 16'h0);
        rst = 1'b1;

        // Async reset in the middle of a right burst.
        drv(1'b1, 1'b0, 2'b01, 16'h1234, 1'b0, 1'b0, 5'd0, 1'b0);
        exp_edge(16'h1234, 1'b0, 1'b0, 1'b0, "rstb.load");
        drv(1'b1, 1'b0, 2'b00, 16'h0, 1'b0, 1'b1, 5'd5, 1'b0);
        exp_edge(16'h1234, 1'b0, 1'b1, 1'b0, "rstb.start");
        start = 1'b0;
        exp_edge(16'h091A, 1'b0, 1'b1, 1'b0, "rstb.sh1");
        exp_edge(16'h048D, 1'b0, 1'b1, 1'b0, "rstb.sh2");
        #2 rst = 1'b0;
        #1;
        cmp("rstb.async.Q", Q, 16'h0);
        cmp("rstb.async.busy", {15'h0, busy}, 16'h0);
        cmp("rstb.async.done", {15'h0, done}, 16'h0);
        @(negedge clk);
        rst = 1'b1;
        exp_edge(16'h0000, 1'b0, 1'b0, 1'b0, "rstb.hold");

        // Single-cycle op table.
        for (int i = 0; i < 11; i++) begin
            drv(vt[i].ebl, vt[i].clr, vt[i].op, vt[i].l, vt[i].sin, 1'b0, 5'd0, 1'b0);
            exp_edge(vt[i].q, vt[i].sout, 1'b0, 1'b0, $sformatf("vec%0d", i));
        end

        // Burst right by 3; op on the start edge and during busy is ignored.
        drv(1'b1, 1'b0, 2'b01, 16'hFFFF, 1'b1, 1'b1, 5'd3, 1'b0);
        exp_edge(16'hA5F0, 1'b0, 1'b1, 1'b0, "bur.start");
        start = 1'b0;
        exp_edge(16'hD2F8, 1'b0, 1'b1, 1'b0, "bur.sh1");
        op = 2'b11;
        exp_edge(16'hE97C, 1'b0, 1'b1, 1'b0, "bur.sh2");
        exp_edge(16'hF4BE, 1'b0, 1'b0, 1'b1, "bur.sh3");
        op = 2'b00;
        exp_edge(16'hF4BE, 1'b0, 1'b0, 1'b0, "bur.after");

        // Same burst with a two-cycle stall, then a stalled done pulse.
        drv(1'b1, 1'b0, 2'b01, 16'hA5F0, 1'b0, 1'b0, 5'd0, 1'b0);
        exp_edge(16'hA5F0, 1'b0, 1'b0, 1'b0, "stl.load");
        drv(1'b1, 1'b0, 2'b00, 16'h0, 1'b1, 1'b1, 5'd3, 1'b0);
        exp_edge(16'hA5F0, 1'b0, 1'b1, 1'b0, "stl.start");
        start = 1'b0;
        exp_edge(16'hD2F8, 1'b0, 1'b1, 1'b0, "stl.sh1");
        ebl = 1'b0; op = 2'b01; L = 16'h5555;
        exp_edge(16'hD2F8, 1'b0, 1'b1, 1'b0, "stl.wait1");
        op = 2'b11;
        exp_edge(16'hD2F8, 1'b0, 1'b1, 1'b0, "stl.wait2");
        ebl = 1'b1; op = 2'b10;
        exp_edge(16'hE97C, 1'b0, 1'b1, 1'b0, "stl.sh2");
        exp_edge(16'hF4BE, 1'b0, 1'b0, 1'b1, "stl.sh3");
        ebl = 1'b0; op = 2'b00;
        exp_edge(16'hF4BE, 1'b0, 1'b0, 1'b1, "stl.donehold");
        ebl = 1'b1;
        exp_edge(16'hF4BE, 1'b0, 1'b0, 1'b0, "stl.doneclr");

        // Clear aborts a left burst after 3 shifts: no done, sout kept.
        drv(1'b1, 1'b0, 2'b01, 16'hF0FF, 1'b0, 1'b0, 5'd0, 1'b0);
        exp_edge(16'hF0FF, 1'b0, 1'b0, 1'b0, "clr.load");
        drv(1'b1, 1'b0, 2'b00, 16'h0, 1'b0, 1'b1, 5'd8, 1'b1);
        exp_edge(16'hF0FF, 1'b0, 1'b1, 1'b0, "clr.start");
        start = 1'b0;
        exp_edge(16'hE1FE, 1'b1, 1'b1, 1'b0, "clr.sh1");
        exp_edge(16'hC3FC, 1'b1, 1'b1, 1'b0, "clr.sh2");
        exp_edge(16'h87F8, 1'b1, 1'b1, 1'b0, "clr.sh3");
        clr = 1'b1;
        exp_edge(16'h0000, 1'b1, 1'b0, 1'b0, "clr.abort");
        clr = 1'b0;
        exp_edge(16'h0000, 1'b1, 1'b0, 1'b0, "clr.nodone");

        // amt=0 completes at once; new start accepted in the done cycle.
        drv(1'b1, 1'b0, 2'b01, 16'h0001, 1'b0, 1'b0, 5'd0, 1'b0);
        exp_edge(16'h0001, 1'b1, 1'b0, 1'b0, "b2b.load");
        drv(1'b1, 1'b0, 2'b00, 16'h0, 1'b0, 1'b1, 5'd0, 1'b1);
        exp_edge(16'h0001, 1'b1, 1'b0, 1'b1, "b2b.zero");
        drv(1'b1, 1'b0, 2'b00, 16'h0, 1'b1, 1'b1, 5'd2, 1'b1);
        exp_edge(16'h0001, 1'b1, 1'b1, 1'b0, "b2b.start");
        start = 1'b0;
        exp_edge(16'h0003, 1'b0, 1'b1, 1'b0, "b2b.sh1");
        exp_edge(16'h0007, 1'b0, 1'b0, 1'b1, "b2b.sh2");
        exp_edge(16'h0007, 1'b0, 1'b0, 1'b0, "b2b.after");

        // amt beyond WIDTH: exactly 17 left shifts of ones.
        drv(1'b1, 1'b0, 2'b01, 16'h0000, 1'b0, 1'b0, 5'd0, 1'b0);
        exp_edge(16'h0000, 1'b0, 1'b0, 1'b0, "long.load");
        drv(1'b1, 1'b0, 2'b00, 16'h0, 1'b1, 1'b1, 5'd17, 1'b1);
        exp_edge(16'h0000, 1'b0, 1'b1, 1'b0, "long.start");
        start = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            logic [W-1:0] qe;
            qe = (i >= 16) ? 16'hFFFF : ((16'h0001 << i) - 16'h0001);
            exp_edge(qe, (i == 17), (i < 17), (i == 17), $sformatf("long.sh%0d", i));
        end
        exp_edge(16'hFFFF, 1'b1, 1'b0, 1'b0, "long.after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/shift_load_register.md
# shift_load_register

Parametrised successor to the 16-bit load/hold register used in the shift-and-add multiplier datapath. It holds a WIDTH-bit word and supports hold, parallel load, single-step shift right or left with serial input, and synchronous clear. It also runs autonomous multi-cycle shift bursts under a start/busy/done handshake. The multiplier controller uses it as accumulator or multiplier register, so shift sequencing is no longer done bit-by-bit from the controller. Enable is synchronous and the clock is never gated.

## Interface
- WIDTH, 16, register width in bits (≥ 2)
- CNT_W, $clog2(WIDTH+1), width of burst count
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- ebl  in  1  synchronous enable; low freezes all state (register, counter, FSM, done)
- clr  in  1  synchronous clear of Q, highest priority when ebl=1
- op  in  2  single-cycle op: 00 hold, 01 load L, 10 shift right, 11 shift left
- L  in  WIDTH  parallel load data
- sin  in  1  serial input bit (MSB side for right shift, LSB side for left shift)
- start  in  1  begin burst shift, sampled in IDLE only
- amt  in  CNT_W  burst shift count
- dir  in  1  burst direction: 0 right, 1 left
- Q  out  WIDTH  register contents
- sout  out  1  registered copy of the last bit shifted out
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse when a burst completes

## Operation
- Reset: Q=0, sout=0, busy=0, done=0, count=0, FSM=IDLE. Reset takes effect immediately, including during a burst.
- FSM states:
  - IDLE
    - start & amt≠0 → SHIFT, count←amt, dir latched.
    - start & amt=0 → stay IDLE, done←1.
    - Otherwise op executes.
  - SHIFT
    - Each enabled edge: one shift in latched dir with current sin, count←count−1.
    - At count=1: shift, → IDLE, done←1.
- Priority at an enabled edge: clr > SHIFT activity > start > op.
  - clr in SHIFT: Q←0, abort to IDLE, done stays 0, sout unchanged.
  - start while busy is ignored.
  - op is ignored while busy.
  - op is ignored on the edge start is accepted.
- Shift right: Q←{sin, Q[WIDTH-1:1]}, sout←Q[0]. Shift left: Q←{Q[WIDTH-2:0], sin}, sout←Q[WIDTH-1].
- Load and hold leave sout unchanged.
- amt > WIDTH is legal; it performs exactly amt shifts.
- done is 0 on every edge other than a completion edge.
- busy = (state==SHIFT), decoded from registered state.

## Timing
- Single-op latency: one edge. Q updates at the edge where op is sampled with ebl=1.
- Burst accepted at edge k (amt=N≥1): busy high after k. Shifts occur at enabled edges k+1…k+N. done high for one cycle after edge k+N, busy low after k+N.
- With amt=0: done high for one cycle after edge k, busy never asserted.
- ebl=0 cycles insert stalls: no shift, count unchanged, done held at its current value (a pending done pulse extends until the next enabled edge clears it).
- A new start is accepted in the cycle done is high (FSM already IDLE).
- sin is sampled on every shifting edge; the source must present it per cycle.

## Structure
- Package shift_load_pkg: op encodings (OP_HOLD, OP_LOAD, OP_SHR, OP_SHL), FSM state enum (ST_IDLE, ST_SHIFT), direction constants.
- Sub-module shift_cell: one bit consisting of a 4:1 next-state mux (hold/load/from-left/from-right) plus flop with async active-low reset. Instantiate it WIDTH times with a generate loop. Control decode and FSM stay in the top.

## Test plan
- Reset mid-burst: load 0x1234, start amt=5, assert rst after 2 shifts → Q=0, busy=0, done=0 immediately. After release, op=00 holds 0.
- Load/single ops: load 0x8001, op=11 sin=0 → Q=0x0002, sout=1. Then op=10 sin=1 → Q=0x8001, sout=0.
- Burst right: Q=0xA5F0, start amt=3 dir=0 sin=1 → busy for 3 cycles, Q=0xF4BE, sout=0, done pulse exactly once.
- Stall: same burst with ebl=0 for 2 cycles after the first shift → completion delayed by 2 cycles, same final Q. op changes during busy have no effect.
- Clear abort: start amt=8, clr after 3 shifts → Q=0, busy=0 next cycle, no done pulse.
- amt=0 and back-to-back: start amt=0 → done one cycle, Q unchanged. start amt=2 in the done cycle → accepted, 2 shifts, second done.
